add_acc_sched: RTL and testbench

- Sequencer that reduces a stream of N 12-bit floats ({sgn, exp[4:0] bias 15, man[5:0]}) to one sum using a single shared add_en_12 adder instance, which is external and has 5-cycle latency.
- Hides adder latency by interleaving up to ADD_LAT partial sums, recirculating them through the adder, then pairwise-reducing them to one result.
- Sits between the neuron dot-product stage and the activation/output buffer.

---
 rtl/float12_pkg.sv | 17 +
 rtl/lat_token_pipe.sv | 23 ++
 rtl/add_acc_sched.sv | 154 +++++++++++++++
 tb/tb_add_acc_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/float12_pkg.sv
// Shared 12-bit float format constants and sequencer state encoding.
package float12_pkg;

    localparam int FP_W         = 12;
    localparam int EXP_W        = 5;
    localparam int MAN_W        = 6;
    localparam int EXP_BIAS     = 15;
    localparam int ADD_EN12_LAT = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/lat_token_pipe.sv
// Token shift register that tracks which adder pipeline slots carry live data.
module lat_token_pipe #(
    parameter int LAT = 5
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic token_i,
    output logic live_o
);

    logic [LAT-1:0] pipe;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pipe <= '0;
        end else begin
            pipe <= (pipe << 1) | LAT'(token_i);
        end
    end

    assign live_o = pipe[LAT-1];

endmodule

// File: rtl/add_acc_sched.sv
// Reduces a stream of 12-bit floats to one sum through a shared external
// adder, interleaving partial sums to hide the adder latency.
//
// state  | meaning
// IDLE   | waiting for start_i; adder idle
// ACCUM  | accepting elements, folding them into in-flight partial sums
// REDUCE | pairwise combining the remaining partial sums
// DONE   | publish result (optionally ReLU-clamped) and pulse done_o
module add_acc_sched
    import float12_pkg::*;
#(
    parameter int ADD_LAT = ADD_EN12_LAT,
    parameter int CNT_W   = 10
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             relu_i,
    output logic             busy_o,
    input  logic [FP_W-1:0]  data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [FP_W-1:0]  sum_o,
    output logic             done_o,
    output logic             add_en_o,
    output logic [FP_W-1:0]  data_1_o,
    output logic [FP_W-1:0]  data_2_o,
    input  logic [FP_W-1:0]  data_sum_i
);

    localparam int LIVE_W = $clog2(ADD_LAT + 1);

    state_t            state;
    logic [CNT_W-1:0]  n_lat;
    logic [CNT_W-1:0]  elem_cnt;
    logic              relu_lat;
    logic [FP_W-1:0]   hold;
    logic              hold_full;
    logic [FP_W-1:0]   result;
    logic [LIVE_W-1:0] live_cnt;
    logic              live_out;
    logic              token;
    logic              accept;
    logic              last_elem;
    logic [FP_W-1:0]   fb;

    lat_token_pipe #(.LAT(ADD_LAT)) u_live_pipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .token_i (token),
        .live_o  (live_out)
    );

    assign ready_o   = (state == ACCUM);
    assign busy_o    = (state != IDLE);
    assign accept    = ready_o & valid_i;
    assign fb        = live_out ? data_sum_i : '0;
    assign last_elem = (elem_cnt == n_lat - CNT_W'(1));

    always_comb begin
        add_en_o = 1'b0;
        data_1_o = '0;
        data_2_o = '0;
        token    = 1'b0;
        case (state)
            ACCUM: begin
                token = accept | live_out;
                if (accept) begin
                    data_1_o = data_i;
                    if (live_out) begin
                        data_2_o = fb;
                        add_en_o = 1'b1;
                    end
                end else begin
                    data_1_o = fb;
                end
            end
            REDUCE: begin
                if (live_out && live_cnt != LIVE_W'(1) && hold_full) begin
                    data_1_o = hold;
                    data_2_o = fb;
                    add_en_o = 1'b1;
                    token    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // live_cnt counts partial sums in flight plus the one parked in hold;
    // it tracks real merges so stalls that fold elements early stay correct.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            n_lat     <= '0;
            elem_cnt  <= '0;
            relu_lat  <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            result    <= '0;
            live_cnt  <= '0;
            sum_o     <= '0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        n_lat     <= count_i;
                        relu_lat  <= relu_i;
                        elem_cnt  <= '0;
                        hold_full <= 1'b0;
                        live_cnt  <= '0;
                        if (count_i == '0) begin
                            result <= '0;
                            state  <= DONE;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        elem_cnt <= elem_cnt + CNT_W'(1);
                        if (!live_out) live_cnt <= live_cnt + LIVE_W'(1);
                        if (last_elem) state <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (live_out) begin
                        if (live_cnt == LIVE_W'(1)) begin
                            result <= fb;
                            state  <= DONE;
                        end else if (!hold_full) begin
                            hold      <= fb;
                            hold_full <= 1'b1;
                        end else begin
                            hold_full <= 1'b0;
                            live_cnt  <= live_cnt - LIVE_W'(1);
                        end
                    end
                end
                DONE: begin
                    sum_o  <= (relu_lat & result[FP_W-1]) ? '0 : result;
                    done_o <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_acc_sched.sv
// Bench for add_acc_sched with a behavioural 5-cycle fp12 adder attached.
`timescale 1ns/1ps
module tb_add_acc_sched;
    import float12_pkg::*;

    localparam int L     = 5;
    localparam int CNT_W = 10;

    logic             clk_i   = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] count_i = '0;
    logic             relu_i  = 1'b0;
    logic             busy_o;
    logic [11:0]      data_i  = '0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [11:0]      sum_o;
    logic             done_o;
    logic             add_en_o;
    logic [11:0]      data_1_o;
    logic [11:0]      data_2_o;
    logic [11:0]      data_sum_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    add_acc_sched #(.ADD_LAT(L), .CNT_W(CNT_W)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (start_i),
        .count_i    (count_i),
        .relu_i     (relu_i),
        .busy_o     (busy_o),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .sum_o      (sum_o),
        .done_o     (done_o),
        .add_en_o   (add_en_o),
        .data_1_o   (data_1_o),
        .data_2_o   (data_2_o),
        .data_sum_i (data_sum_i)
    );

    function automatic real fp2r(input logic [11:0] f);
        real m;
        int  e;
        if (f[10:6] == 5'd0) return 0.0;
        m = 1.0 + real'(int'(f[5:0])) / 64.0;
        e = int'(f[10:6]) - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[11] ? -m : m;
    endfunction

    function automatic logic [11:0] r2fp(input real r);
        real  a;
        int   e;
        int   m;
        logic s;
        if (r == 0.0) return 12'h000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > -2) begin a = a * 2.0; e--; end
        m = int'((a - 1.0) * 64.0);
        if (m >= 64) begin m = 0; e++; end
        if (e <= 0) return 12'h000;
        if (e >= 31) begin e = 30; m = 63; end
        return {s, 5'(e), 6'(m)};
    endfunction

    // Behavioural adder: passes data_1 (flushed) through when add_en is low.
    logic [11:0] add_pipe [L];
    always @(posedge clk_i) begin
        add_pipe[0] <= add_en_o ? r2fp(fp2r(data_1_o) + fp2r(data_2_o))
                                : ((data_1_o[10:6] == 5'd0) ? 12'h000 : data_1_o);
        for (int k = 1; k < L; k++) add_pipe[k] <= add_pipe[k-1];
    end
    assign data_sum_i = add_pipe[L-1];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    logic [11:0] exp_q[$];
    int adds_accum = 0;
    int adds_reduce = 0;
    int dones = 0;
    int ready_seen = 0;

    always @(posedge clk_i) begin
        if (rst_n_i && add_en_o) begin
            if (ready_o) adds_accum++;
            else adds_reduce++;
        end
    end

    always @(negedge clk_i) begin
        logic [11:0] e;
        if (ready_o) ready_seen++;
        if (done_o) begin
            dones++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", int'(sum_o), -1);
            end else begin
                e = exp_q.pop_front();
                chk("sum", int'(sum_o), int'(e));
            end
        end
    end

    typedef struct {
        int          n;
        logic        relu;
        logic [11:0] first;
        logic [11:0] rest;
        int          max_gap;
        logic [11:0] exp_sum;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int d0;
        int gap;
        int wc;
        bit stuck;
        stuck = 0;
        @(negedge clk_i); #1;
        adds_accum = 0; adds_reduce = 0; ready_seen = 0; d0 = dones;
        start_i = 1'b1; count_i = CNT_W'(v.n); relu_i = v.relu;
        exp_q.push_back(v.exp_sum);
        @(negedge clk_i); #1;
        start_i = 1'b0;
        for (int i = 0; i < v.n && !stuck; i++) begin
            gap = (v.max_gap > 0) ? int'($urandom_range(v.max_gap, 0)) : 0;
            repeat (gap) begin valid_i = 1'b0; @(negedge clk_i); #1; end
            valid_i = 1'b1;
            data_i  = (i == 0) ? v.first : v.rest;
            wc = 0;
            while (!ready_o && wc < 50) begin @(negedge clk_i); #1; wc++; end
            if (!ready_o) begin
                chk("accept_timeout", i, v.n);
                stuck = 1;
            end else begin
                @(negedge clk_i); #1;
            end
        end
        valid_i = 1'b0;
        wc = 0;
        while (dones == d0 && wc < 200) begin @(negedge clk_i); #1; wc++; end
        chk("done_count", dones - d0, 1);
        if (dones == d0) exp_q.delete();
        @(negedge clk_i); #1;
        chk("done_width", int'(done_o), 0);
        chk("busy_idle", int'(busy_o), 0);
        chk("adds_total", adds_accum + adds_reduce, (v.n > 0) ? v.n - 1 : 0);
        if (v.max_gap == 0) chk("adds_accum", adds_accum, (v.n > L) ? v.n - L : 0);
        if (v.n == 0) chk("ready_never", ready_seen, 0);
    endtask

    vec_t vecs[10];

    initial begin
        int d0;
        vec_t v3;
        //        n   relu  first    rest     gap  expected
        vecs[0] = '{0,  1'b0, 12'h000, 12'h000, 0, 12'h000};
        vecs[1] = '{1,  1'b0, 12'h3C0, 12'h3C0, 0, 12'h3C0};
        vecs[2] = '{4,  1'b0, 12'h3C0, 12'h3C0, 0, 12'h440};
        vecs[3] = '{10, 1'b0, 12'h3C0, 12'h3C0, 0, 12'h490};
        vecs[4] = '{10, 1'b0, 12'h3C0, 12'h3C0, 7, 12'h490};
        vecs[5] = '{2,  1'b0, 12'h3C0, 12'hC00, 0, 12'hBC0};
        vecs[6] = '{2,  1'b1, 12'h3C0, 12'hC00, 0, 12'h000};
        vecs[7] = '{7,  1'b0, 12'h3C0, 12'h3C0, 3, 12'h470};
        vecs[8] = '{6,  1'b0, 12'h3C0, 12'hC00, 2, 12'hC88};
        vecs[9] = '{6,  1'b1, 12'h3C0, 12'hC00, 0, 12'h000};

        #12;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_ready", int'(ready_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_sum", int'(sum_o), 0);
        @(negedge clk_i); #1;
        rst_n_i = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Abort mid-ACCUM: reset must drop busy at once and suppress done.
        @(negedge clk_i); #1;
        start_i = 1'b1; count_i = CNT_W'(8); relu_i = 1'b0;
        @(negedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) begin valid_i = 1'b1; data_i = 12'h3C0; @(negedge clk_i); #1; end
        valid_i = 1'b0;
        chk("abort_busy_before", int'(busy_o), 1);
        d0 = dones;
        #1 rst_n_i = 1'b0;
        #1;
        chk("abort_busy_async", int'(busy_o), 0);
        chk("abort_ready", int'(ready_o), 0);
        repeat (12) @(negedge clk_i);
        chk("abort_no_done", dones - d0, 0);
        #1 rst_n_i = 1'b1;

        v3 = '{3, 1'b0, 12'h3C0, 12'h3C0, 0, 12'h420};   // 3.0
        run_vec(v3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
